// File: rtl/gestor_pkg.sv
// Shared constants and state encoding for the plant-needs manager.
package gestor_pkg;

  localparam int MAX_NIVEL = 7;
  localparam int NIVEL_W   = 3;
  localparam int CNT_W     = 8;

  localparam int DEF_PER_HUM = 10;
  localparam int DEF_PER_NUT = 15;
  localparam int DEF_PER_ENE = 20;
  localparam int DEF_PER_MAN = 25;
  localparam int DEF_PER_POD = 30;
  localparam int DEF_PER_REC = 5;

  typedef enum logic {
    ACTIVO = 1'b0,
    REPOSO = 1'b1
  } estado_t;

endpackage

// File: rtl/canal_necesidad.sv
// One need level (0..MAX_NIVEL) with its own tick-driven decay counter.
module canal_necesidad
  import gestor_pkg::*;
#(
  parameter int PERIOD = DEF_PER_HUM
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               inc,
  input  logic               hold,
  input  logic               reload,
  output logic [NIVEL_W-1:0] level
);

  localparam logic [CNT_W-1:0]   PER = CNT_W'(PERIOD);
  localparam logic [NIVEL_W-1:0] MAX = NIVEL_W'(MAX_NIVEL);

  logic [CNT_W-1:0] cnt;
  logic             decay;

  assign decay = tick && !hold && (cnt == CNT_W'(1));

  // An increment wins over a coincident decay; either one reloads the counter only once.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= PER;
      level <= MAX;
    end else begin
      if (reload || decay || (inc && !hold))
        cnt <= PER;
      else if (tick && !hold)
        cnt <= cnt - CNT_W'(1);

      if (inc) begin
        if (level != MAX)
          level <= level + NIVEL_W'(1);
      end else if (decay && (level != '0)) begin
        level <= level - NIVEL_W'(1);
      end
    end
  end

endmodule

// File: rtl/gestor_necesidades.sv
// Five need channels plus the awake/asleep FSM and the energy recovery counter.
module gestor_necesidades
  import gestor_pkg::*;
#(
  parameter int PER_HUM = DEF_PER_HUM,
  parameter int PER_NUT = DEF_PER_NUT,
  parameter int PER_ENE = DEF_PER_ENE,
  parameter int PER_MAN = DEF_PER_MAN,
  parameter int PER_POD = DEF_PER_POD,
  parameter int PER_REC = DEF_PER_REC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               btn_regar,
  input  logic               btn_alimentar,
  input  logic               btn_sol,
  input  logic               btn_limpiar,
  input  logic               btn_podar,
  input  logic               btn_dormir,
  output logic [NIVEL_W-1:0] humedad,
  output logic [NIVEL_W-1:0] nutricion,
  output logic [NIVEL_W-1:0] energia,
  output logic [NIVEL_W-1:0] mantenimiento,
  output logic [NIVEL_W-1:0] podado,
  output logic               reposando
);

  localparam logic [CNT_W-1:0] REC = CNT_W'(PER_REC);

  estado_t          state, state_next;
  logic [CNT_W-1:0] rec_cnt;
  logic             activo, cambio, rec_event, inc_ene;

  assign activo    = (state == ACTIVO);
  assign cambio    = (state_next != state);
  assign rec_event = !activo && tick && (rec_cnt == CNT_W'(1));
  assign inc_ene   = activo ? btn_sol : rec_event;
  assign reposando = (state == REPOSO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACTIVO;
      rec_cnt <= REC;
    end else begin
      state <= state_next;
      if (cambio || rec_event)
        rec_cnt <= REC;
      else if (!activo && tick)
        rec_cnt <= rec_cnt - CNT_W'(1);
    end
  end

  // Waking is automatic one cycle after energia has been registered at full.
  always_comb begin
    state_next = state;
    case (state)
      ACTIVO:  if (btn_dormir) state_next = REPOSO;
      REPOSO:  if (btn_dormir || (energia == NIVEL_W'(MAX_NIVEL))) state_next = ACTIVO;
      default: state_next = ACTIVO;
    endcase
  end

  canal_necesidad #(.PERIOD(PER_HUM)) u_hum (
    .clk(clk), .rst(rst), .tick(tick), .inc(activo && btn_regar),
    .hold(1'b0), .reload(1'b0), .level(humedad)
  );

  canal_necesidad #(.PERIOD(PER_NUT)) u_nut (
    .clk(clk), .rst(rst), .tick(tick), .inc(activo && btn_alimentar),
    .hold(1'b0), .reload(1'b0), .level(nutricion)
  );

  canal_necesidad #(.PERIOD(PER_ENE)) u_ene (
    .clk(clk), .rst(rst), .tick(tick), .inc(inc_ene),
    .hold(!activo), .reload(cambio), .level(energia)
  );

  canal_necesidad #(.PERIOD(PER_MAN)) u_man (
    .clk(clk), .rst(rst), .tick(tick), .inc(activo && btn_limpiar),
    .hold(1'b0), .reload(1'b0), .level(mantenimiento)
  );

  canal_necesidad #(.PERIOD(PER_POD)) u_pod (
    .clk(clk), .rst(rst), .tick(tick), .inc(activo && btn_podar),
    .hold(1'b0), .reload(1'b0), .level(podado)
  );

endmodule

// File: tb/tb_gestor_necesidades.sv
// Directed bench for gestor_necesidades with default periods and hand-computed levels.
module tb_gestor_necesidades;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       btn_regar = 1'b0, btn_alimentar = 1'b0, btn_sol = 1'b0;
  logic       btn_limpiar = 1'b0, btn_podar = 1'b0, btn_dormir = 1'b0;
  logic [2:0] humedad, nutricion, energia, mantenimiento, podado;
  logic       reposando;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] B_NONE  = 6'b000000;
  localparam logic [5:0] B_REGAR = 6'b100000;
  localparam logic [5:0] B_ALIM  = 6'b010000;
  localparam logic [5:0] B_SOL   = 6'b001000;
  localparam logic [5:0] B_LIMP  = 6'b000100;
  localparam logic [5:0] B_DORM  = 6'b000001;
  localparam logic [5:0] B_ALL   = 6'b111111;

  always #5 clk = ~clk;

  gestor_necesidades dut (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_regar(btn_regar), .btn_alimentar(btn_alimentar), .btn_sol(btn_sol),
    .btn_limpiar(btn_limpiar), .btn_podar(btn_podar), .btn_dormir(btn_dormir),
    .humedad(humedad), .nutricion(nutricion), .energia(energia),
    .mantenimiento(mantenimiento), .podado(podado), .reposando(reposando)
  );

  // Inputs change on the falling edge and are released 1 time unit after the rising edge.
  task automatic applyStimulus(input logic t, input logic [5:0] b, input logic r);
    @(negedge clk);
    rst  = r;
    tick = t;
    {btn_regar, btn_alimentar, btn_sol, btn_limpiar, btn_podar, btn_dormir} = b;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    tick = 1'b0;
    {btn_regar, btn_alimentar, btn_sol, btn_limpiar, btn_podar, btn_dormir} = B_NONE;
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, B_NONE, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkLevels(input string tag, input int h, input int n, input int e,
                             input int m, input int p, input int r);
    checkOutput({tag, ".hum"}, 8'(humedad), 8'(h));
    checkOutput({tag, ".nut"}, 8'(nutricion), 8'(n));
    checkOutput({tag, ".ene"}, 8'(energia), 8'(e));
    checkOutput({tag, ".man"}, 8'(mantenimiento), 8'(m));
    checkOutput({tag, ".pod"}, 8'(podado), 8'(p));
    checkOutput({tag, ".rep"}, 8'(reposando), 8'(r));
  endtask

  initial begin
    // Reset must dominate a tick and every button in the same cycle.
    applyStimulus(1'b1, B_ALL, 1'b1);
    checkLevels("reset", 7, 7, 7, 7, 7, 0);

    runTicks(9);
    checkOutput("t9.hum", 8'(humedad), 8'd7);
    runTicks(1);
    checkLevels("t10", 6, 7, 7, 7, 7, 0);

    runTicks(9);
    applyStimulus(1'b1, B_REGAR, 1'b0);
    checkOutput("t20.hum_regar", 8'(humedad), 8'd7);
    checkOutput("t20.ene", 8'(energia), 8'd6);
    runTicks(9);
    checkOutput("t29.hum_reloaded", 8'(humedad), 8'd7);
    runTicks(1);
    checkLevels("t30", 6, 5, 6, 6, 6, 0);

    applyStimulus(1'b0, B_DORM | B_LIMP, 1'b0);
    checkOutput("dormir_limpiar.rep", 8'(reposando), 8'd1);
    checkOutput("dormir_limpiar.man", 8'(mantenimiento), 8'd7);
    applyStimulus(1'b0, B_ALIM, 1'b0);
    checkOutput("reposo_alim.nut", 8'(nutricion), 8'd5);
    applyStimulus(1'b0, B_SOL | B_REGAR, 1'b0);
    checkOutput("reposo_sol.ene", 8'(energia), 8'd6);
    checkOutput("reposo_regar.hum", 8'(humedad), 8'd6);
    applyStimulus(1'b0, B_DORM, 1'b0);
    checkOutput("despertar.rep", 8'(reposando), 8'd0);
    applyStimulus(1'b0, B_NONE, 1'b0);
    checkLevels("idle", 6, 5, 6, 7, 6, 0);

    applyStimulus(1'b0, B_NONE, 1'b1);
    runTicks(80);
    checkLevels("t80", 0, 2, 3, 4, 5, 0);
    runTicks(10);
    checkLevels("t90", 0, 1, 3, 4, 4, 0);

    applyStimulus(1'b0, B_DORM, 1'b0);
    checkOutput("sleep.rep", 8'(reposando), 8'd1);
    checkOutput("sleep.ene", 8'(energia), 8'd3);
    runTicks(19);
    checkOutput("rec19.ene", 8'(energia), 8'd6);
    checkOutput("rec19.rep", 8'(reposando), 8'd1);
    runTicks(1);
    checkOutput("rec20.ene", 8'(energia), 8'd7);
    checkOutput("rec20.rep", 8'(reposando), 8'd1);
    applyStimulus(1'b0, B_NONE, 1'b0);
    checkLevels("auto_wake", 0, 0, 7, 3, 4, 0);

    applyStimulus(1'b0, B_DORM, 1'b0);
    checkOutput("sleep2.rep", 8'(reposando), 8'd1);
    runTicks(3);
    applyStimulus(1'b1, B_ALL, 1'b1);
    checkLevels("reset_reposo", 7, 7, 7, 7, 7, 0);
    applyStimulus(1'b0, B_NONE, 1'b0);
    checkOutput("post_reset.rep", 8'(reposando), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gestor_necesidades.md
GESTOR_NECESIDADES -- requirements
Module: gestor_necesidades

Interface
REQ-001 Parameter PER_HUM, default 10, ticks between humedad decrements.
REQ-002 Parameter PER_NUT, default 15, ticks between nutricion decrements.
REQ-003 Parameter PER_ENE, default 20, ticks between energia decrements while awake.
REQ-004 Parameter PER_MAN, default 25, ticks between mantenimiento decrements.
REQ-005 Parameter PER_POD, default 30, ticks between podado decrements.
REQ-006 Parameter PER_REC, default 5, ticks between energia increments while asleep.
REQ-007 Ports SHALL be:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- tick  input  1  one-cycle time-base pulse (1 s)
- btn_regar  input  1  one-cycle debounced pulse; water
- btn_alimentar  input  1  one-cycle debounced pulse; feed
- btn_sol  input  1  one-cycle debounced pulse; sun
- btn_limpiar  input  1  one-cycle debounced pulse; clean
- btn_podar  input  1  one-cycle debounced pulse; prune
- btn_dormir  input  1  one-cycle debounced pulse; rest toggle
- humedad, nutricion, energia, mantenimiento, podado  output  3 each  need levels, 0..7
- reposando  output  1  high while asleep
REQ-008 All outputs SHALL be registered and feed MaquinaEstados directly.

Function
REQ-009 Each level SHALL have its own 8-bit tick down-counter, loaded with its period.
REQ-010 On a tick, a counter at 1 SHALL reload its period and fire a decay event; otherwise it decrements.
REQ-011 A decay event SHALL decrement its level by 1, saturating at 0.
REQ-012 An action pulse SHALL increment its mapped level by 1, saturating at 7: regar->humedad, alimentar->nutricion, sol->energia, limpiar->mantenimiento, podar->podado.
REQ-013 An action pulse SHALL reload that level's decay counter in the same cycle.
REQ-014 If an action and a decay event hit the same level in the same cycle, the level SHALL end at min(level+1,7) and the counter SHALL reload once.
REQ-015 Level updates SHALL be visible on outputs one clock after the triggering tick or pulse.
REQ-016 The FSM SHALL have two states: ACTIVO (reposando=0) and REPOSO (reposando=1).
REQ-017 ACTIVO->REPOSO SHALL occur on btn_dormir.
REQ-018 REPOSO->ACTIVO SHALL occur on btn_dormir, or automatically on the cycle after energia reaches 7.
REQ-019 In REPOSO, all action buttons SHALL be ignored.
REQ-020 In REPOSO, energia SHALL increment every PER_REC ticks, saturating at 7, using its own recovery counter; the energia decay counter SHALL hold.
REQ-021 In REPOSO, the other four levels SHALL continue to decay normally.
REQ-022 On any state change, the energia decay and recovery counters SHALL reload.
REQ-023 If btn_dormir and an action pulse arrive together in ACTIVO, the action SHALL apply and the state SHALL still change.
REQ-024 Inputs with tick=0 and no pulse SHALL leave all state unchanged.

Reset
REQ-025 rst SHALL be sampled on the rising clk edge only.
REQ-026 On reset, all levels SHALL be 7, reposando 0, the state ACTIVO, and every counter loaded with its period.
REQ-027 Reset SHALL override tick and all pulses in the same cycle, including reset during REPOSO.

Structure
REQ-028 Package gestor_pkg SHALL hold MAX_NIVEL=7, the default periods, the counter width (8), and the state encoding.
REQ-029 Sub-module canal_necesidad SHALL implement one level and its decay counter, with inputs inc, hold and reload.
REQ-030 gestor_necesidades SHALL instantiate canal_necesidad five times and contain the rest FSM and recovery counter.

Verification
REQ-031 Reset, then 10 ticks -> humedad=6 after the 10th tick, all other levels 7.
REQ-032 Reset, then 80 ticks -> humedad=0 and stays 0 at tick 90, showing saturation.
REQ-033 humedad=6 with btn_regar coincident with the 10th-tick decay -> humedad=7 and the counter reloads to 10.
REQ-034 energia=3 with btn_dormir -> reposando=1; 20 ticks later energia=7, then reposando=0 on the next cycle.
REQ-035 In REPOSO, apply btn_alimentar with nutricion=5 -> nutricion stays 5.
REQ-036 rst asserted mid-REPOSO with mixed levels -> next cycle all levels 7, reposando=0.
